// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
// The fetch stage is the master; the memory is the slave.
interface fetch_unit_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;

  modport master (output i_req, output i_addr, input i_ack, input i_rdata);
  modport slave  (input i_req, input i_addr, output i_ack, output i_rdata);
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, runs the imem req/ack handshake and
// produces the F-stage bundle (instrF, pcF, ExcCodeF, bdF) with f_ready.
module fetch_unit #(
  parameter logic [31:0] PC_RESET  = 32'h0000_3000,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter logic [31:0] IMEM_LO   = 32'h0000_3000,
  parameter logic [31:0] IMEM_HI   = 32'h0000_6ffc
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               req,
  input  logic               eretD,
  input  logic [31:0]        epc,
  input  logic               npc_sel,
  input  logic [31:0]        npc,
  input  logic               branchD,
  fetch_unit_if.master       imem,
  output logic [31:0]        pcF,
  output logic [31:0]        instrF,
  output logic [4:0]         ExcCodeF,
  output logic               bdF,
  output logic               f_ready
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    READY = 2'd1,
    DRAIN = 2'd2
  } st_t;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  st_t         st_r, st_nxt_s;
  logic [31:0] pc_r, pc_nxt_s;
  logic [31:0] req_addr_r, req_addr_nxt_s;
  logic [31:0] ibuf_r, ibuf_nxt_s;

  logic        adel_s;
  logic        i_req_s;
  logic        f_ready_s;
  logic [31:0] instr_s;
  logic [4:0]  exc_s;
  logic        consume_s;
  logic        pc_upd_s;
  logic        busy_s;

  function automatic logic is_adel(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || (addr < IMEM_LO) || (addr > IMEM_HI);
  endfunction

  assign adel_s = is_adel(pc_r);

  // F bundle and memory request, decoded from the current state
  always_comb begin
    i_req_s   = 1'b0;
    f_ready_s = 1'b0;
    instr_s   = 32'h0000_0000;
    exc_s     = EXC_NONE;
    case (st_r)
      FETCH: begin
        if (adel_s) begin
          f_ready_s = 1'b1;
          exc_s     = EXC_ADEL;
        end else begin
          i_req_s = 1'b1;
          if (imem.i_ack) begin
            f_ready_s = 1'b1;
            instr_s   = imem.i_rdata;
          end else begin
            f_ready_s = 1'b0;
          end
        end
      end
      READY: begin
        f_ready_s = 1'b1;
        instr_s   = ibuf_r;
      end
      DRAIN: begin
        i_req_s = 1'b1;
      end
      default: begin
        i_req_s = 1'b0;
      end
    endcase
  end

  assign consume_s = en & f_ready_s;

  // Next-PC selection: exception entry beats eret beats normal advance
  always_comb begin
    pc_upd_s = 1'b0;
    pc_nxt_s = pc_r;
    if (req) begin
      pc_upd_s = 1'b1;
      pc_nxt_s = EXC_ENTRY;
    end else if (eretD && en) begin
      pc_upd_s = 1'b1;
      pc_nxt_s = epc;
    end else if (consume_s) begin
      pc_upd_s = 1'b1;
      pc_nxt_s = npc_sel ? npc : (pc_r + 32'd4);
    end else begin
      pc_upd_s = 1'b0;
      pc_nxt_s = pc_r;
    end
  end

  // A raised request must stay on the bus until acked, even across a redirect
  assign busy_s = i_req_s & ~imem.i_ack & ((st_r == FETCH) | (st_r == DRAIN));

  // Next-state, request address and instruction buffer
  always_comb begin
    st_nxt_s       = st_r;
    req_addr_nxt_s = req_addr_r;
    ibuf_nxt_s     = ibuf_r;
    if ((st_r == FETCH) && !adel_s && imem.i_ack) begin
      ibuf_nxt_s = imem.i_rdata;
    end else begin
      ibuf_nxt_s = ibuf_r;
    end
    if (pc_upd_s) begin
      if (busy_s) begin
        st_nxt_s = DRAIN;
      end else begin
        st_nxt_s       = FETCH;
        req_addr_nxt_s = pc_nxt_s;
      end
    end else begin
      case (st_r)
        FETCH: begin
          if (!adel_s && imem.i_ack) begin
            st_nxt_s = READY;
          end else begin
            st_nxt_s = FETCH;
          end
        end
        READY: begin
          st_nxt_s = READY;
        end
        DRAIN: begin
          if (imem.i_ack) begin
            st_nxt_s       = FETCH;
            req_addr_nxt_s = pc_r;
          end else begin
            st_nxt_s = DRAIN;
          end
        end
        default: begin
          st_nxt_s       = FETCH;
          req_addr_nxt_s = pc_r;
        end
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_r       <= FETCH;
      pc_r       <= PC_RESET;
      req_addr_r <= PC_RESET;
      ibuf_r     <= 32'h0000_0000;
    end else begin
      st_r       <= st_nxt_s;
      pc_r       <= pc_nxt_s;
      req_addr_r <= req_addr_nxt_s;
      ibuf_r     <= ibuf_nxt_s;
    end
  end

  // Outputs are forced quiet for the whole time reset is held
  assign imem.i_req  = reset ? 1'b0 : i_req_s;
  assign imem.i_addr = req_addr_r;
  assign pcF         = reset ? PC_RESET : pc_r;
  assign f_ready     = reset ? 1'b0 : f_ready_s;
  assign instrF      = reset ? 32'h0000_0000 : instr_s;
  assign ExcCodeF    = reset ? EXC_NONE : exc_s;
  assign bdF         = reset ? 1'b0 : (branchD & f_ready_s);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a table of per-cycle vectors against a
// zero-wait memory, then hand-written wait-state, redirect and reset sequences.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        en, req, eretD, npc_sel, branchD;
  logic [31:0] epc, npc;
  logic [31:0] pcF, instrF;
  logic [4:0]  ExcCodeF;
  logic        bdF, f_ready;
  int          waits;
  int          wcnt;
  int          tests = 0;
  int          fails = 0;

  fetch_unit_if mem();

  fetch_unit dut (
    .clk(clk), .reset(reset), .en(en), .req(req), .eretD(eretD), .epc(epc),
    .npc_sel(npc_sel), .npc(npc), .branchD(branchD), .imem(mem),
    .pcF(pcF), .instrF(instrF), .ExcCodeF(ExcCodeF), .bdF(bdF), .f_ready(f_ready)
  );

  always #5 clk = ~clk;

  // Memory model: acks after 'waits' idle cycles, data = addr ^ A5A5_0000
  assign mem.i_ack   = mem.i_req && (wcnt == waits);
  assign mem.i_rdata = mem.i_ack ? (mem.i_addr ^ 32'hA5A5_0000) : 32'h0000_0000;
  always @(posedge clk) begin
    if (mem.i_req && !mem.i_ack) wcnt <= wcnt + 1;
    else                         wcnt <= 0;
  end

  typedef struct {
    logic        en, sel;
    logic [31:0] npc;
    logic        bd, rq, er;
    logic [31:0] epc;
    logic [31:0] e_pc;
    logic        e_rdy;
    logic [31:0] e_instr;
    logic [4:0]  e_exc;
    logic        e_bd, e_ireq;
  } vec_t;

  vec_t tbl[21];

  function automatic vec_t mk(input logic e, input logic s, input logic [31:0] n,
                              input logic b, input logic r, input logic x,
                              input logic [31:0] ep, input logic [31:0] p,
                              input logic rdy, input logic [31:0] ins,
                              input logic [4:0] ex, input logic bf, input logic ir);
    vec_t v;
    v.en = e; v.sel = s; v.npc = n; v.bd = b; v.rq = r; v.er = x; v.epc = ep;
    v.e_pc = p; v.e_rdy = rdy; v.e_instr = ins; v.e_exc = ex; v.e_bd = bf; v.e_ireq = ir;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    en = 1'b0; req = 1'b0; eretD = 1'b0; npc_sel = 1'b0; branchD = 1'b0;
    epc = 32'h0000_0000; npc = 32'h0000_0000;
  endtask

  initial begin
    wcnt = 0;
    waits = 0;
    reset = 1'b1;
    drive_idle();
    tbl[0]  = mk(1,0,32'h0,   0,0,0,32'h0,    32'h3000,1,32'hA5A53000,5'd0,0,1);
    tbl[1]  = mk(1,0,32'h0,   0,0,0,32'h0,    32'h3004,1,32'hA5A53004,5'd0,0,1);
    tbl[2]  = mk(1,0,32'h0,   0,0,0,32'h0,    32'h3008,1,32'hA5A53008,5'd0,0,1);
    tbl[3]  = mk(0,0,32'h0,   0,0,0,32'h0,    32'h300C,1,32'hA5A5300C,5'd0,0,1);
    tbl[4]  = mk(0,0,32'h0,   0,0,0,32'h0,    32'h300C,1,32'hA5A5300C,5'd0,0,0);
    tbl[5]  = mk(1,0,32'h0,   0,0,0,32'h0,    32'h300C,1,32'hA5A5300C,5'd0,0,0);
    tbl[6]  = mk(1,1,32'h3100,0,0,0,32'h0,    32'h3010,1,32'hA5A53010,5'd0,0,1);
    tbl[7]  = mk(1,0,32'h0,   1,0,0,32'h0,    32'h3100,1,32'hA5A53100,5'd0,1,1);
    tbl[8]  = mk(0,0,32'h0,   0,0,1,32'h3002, 32'h3104,1,32'hA5A53104,5'd0,0,1);
    tbl[9]  = mk(0,0,32'h0,   0,0,1,32'h3002, 32'h3104,1,32'hA5A53104,5'd0,0,0);
    tbl[10] = mk(1,0,32'h0,   0,0,1,32'h3002, 32'h3104,1,32'hA5A53104,5'd0,0,0);
    tbl[11] = mk(0,0,32'h0,   0,0,0,32'h0,    32'h3002,1,32'h0,       5'd4,0,0);
    tbl[12] = mk(1,0,32'h0,   0,0,1,32'h7000, 32'h3002,1,32'h0,       5'd4,0,0);
    tbl[13] = mk(0,0,32'h0,   0,0,0,32'h0,    32'h7000,1,32'h0,       5'd4,0,0);
    tbl[14] = mk(1,1,32'h6FFC,0,0,0,32'h0,    32'h7000,1,32'h0,       5'd4,0,0);
    tbl[15] = mk(0,0,32'h0,   0,0,0,32'h0,    32'h6FFC,1,32'hA5A56FFC,5'd0,0,1);
    tbl[16] = mk(0,0,32'h0,   0,1,0,32'h0,    32'h6FFC,1,32'hA5A56FFC,5'd0,0,0);
    tbl[17] = mk(1,0,32'h0,   0,1,1,32'h3000, 32'h4180,1,32'hA5A54180,5'd0,0,1);
    tbl[18] = mk(1,1,32'h2FFC,0,0,0,32'h0,    32'h4180,1,32'hA5A54180,5'd0,0,1);
    tbl[19] = mk(1,1,32'h3000,0,0,0,32'h0,    32'h2FFC,1,32'h0,       5'd4,0,0);
    tbl[20] = mk(0,0,32'h0,   0,0,0,32'h0,    32'h3000,1,32'hA5A53000,5'd0,0,1);

    // Reset values
    @(negedge clk); #2;
    chk("rst_ireq", {31'd0, mem.i_req}, 32'd0);
    chk("rst_rdy",  {31'd0, f_ready}, 32'd0);
    chk("rst_pc",   pcF, 32'h0000_3000);
    chk("rst_instr", instrF, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Zero-wait table
    for (int i = 0; i < 21; i++) begin
      en = tbl[i].en; npc_sel = tbl[i].sel; npc = tbl[i].npc; branchD = tbl[i].bd;
      req = tbl[i].rq; eretD = tbl[i].er; epc = tbl[i].epc;
      #2;
      tests++;
      if (pcF !== tbl[i].e_pc || f_ready !== tbl[i].e_rdy || instrF !== tbl[i].e_instr ||
          ExcCodeF !== tbl[i].e_exc || bdF !== tbl[i].e_bd || mem.i_req !== tbl[i].e_ireq) begin
        fails++;
        $display("FAIL vec%0d: got pc=%h rdy=%b instr=%h exc=%0d bd=%b ireq=%b expected pc=%h rdy=%b instr=%h exc=%0d bd=%b ireq=%b",
                 i, pcF, f_ready, instrF, ExcCodeF, bdF, mem.i_req, tbl[i].e_pc, tbl[i].e_rdy,
                 tbl[i].e_instr, tbl[i].e_exc, tbl[i].e_bd, tbl[i].e_ireq);
      end
      @(negedge clk);
    end

    // Three-wait memory: one instruction every four cycles
    reset = 1'b1; drive_idle(); waits = 3;
    @(negedge clk);
    reset = 1'b0; en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #2;
      chk($sformatf("w3_rdy%0d", k), {31'd0, f_ready}, {31'd0, (k % 4) == 3});
      chk($sformatf("w3_addr%0d", k), mem.i_addr, 32'h3000 + 32'd4 * (k / 4));
      chk($sformatf("w3_pc%0d", k), pcF, 32'h3000 + 32'd4 * (k / 4));
      @(negedge clk);
    end

    // Exception redirect while the 0x3008 request is pending
    #2; chk("pend_addr", mem.i_addr, 32'h3008);
    @(negedge clk); req = 1'b1;
    #2; chk("pend_ireq", {31'd0, mem.i_req}, 32'd1);
    chk("pend_rdy", {31'd0, f_ready}, 32'd0);
    @(negedge clk); req = 1'b0;
    #2; chk("drn_pc", pcF, 32'h0000_4180);
    chk("drn_addr", mem.i_addr, 32'h3008);
    chk("drn_rdy", {31'd0, f_ready}, 32'd0);
    @(negedge clk);
    #2; chk("drn_ack", {31'd0, mem.i_ack}, 32'd1);
    chk("drn_addr2", mem.i_addr, 32'h3008);
    chk("drn_drop", {31'd0, f_ready}, 32'd0);
    chk("drn_instr", instrF, 32'h0);
    @(negedge clk);
    #2; chk("exc_addr", mem.i_addr, 32'h0000_4180);
    chk("exc_ireq", {31'd0, mem.i_req}, 32'd1);
    @(negedge clk); @(negedge clk); @(negedge clk);
    #2; chk("exc_rdy", {31'd0, f_ready}, 32'd1);
    chk("exc_instr", instrF, 32'hA5A5_4180);

    // Reset mid-wait, together with req
    @(negedge clk); @(negedge clk);
    reset = 1'b1; req = 1'b1; branchD = 1'b1;
    #2; chk("mrst_ireq", {31'd0, mem.i_req}, 32'd0);
    chk("mrst_rdy", {31'd0, f_ready}, 32'd0);
    chk("mrst_pc", pcF, 32'h0000_3000);
    chk("mrst_instr", instrF, 32'h0);
    chk("mrst_exc", {27'd0, ExcCodeF}, 32'd0);
    chk("mrst_bd", {31'd0, bdF}, 32'd0);
    @(negedge clk);
    reset = 1'b0; req = 1'b0; branchD = 1'b0;
    #2; chk("rel_ireq", {31'd0, mem.i_req}, 32'd1);
    chk("rel_addr", mem.i_addr, 32'h0000_3000);
    chk("rel_pc", pcF, 32'h0000_3000);
    @(negedge clk); @(negedge clk); @(negedge clk);
    #2; chk("rel_rdy", {31'd0, f_ready}, 32'd1);
    chk("rel_instr", instrF, 32'hA5A5_3000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
